filter_scratchpad: RTL and testbench

Per-PE filter scratchpad that sits directly downstream of the filter read controller: it captures filter words streamed out of the filter buffer while the controller holds its scratchpad write strobe, counts them against the programmed filter length, and then replays the stored filter to the MAC datapath any number of times. The filter is reused across output windows until the block is cleared.

---
 rtl/filter_scratchpad.sv | 99 +++++++++
 tb/tb_filter_scratchpad.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_scratchpad.sv
// filter_scratchpad: captures a streamed filter and replays it to the MAC datapath on demand.
// Optional protocol-error flag enabled by defining FILTER_SP_ERR_EN.
module filter_scratchpad #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [LEN_W-1:0]  len,
    input  logic              sp_wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              start,
    input  logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              ready,
    output logic [LEN_W-1:0]  wcnt,
    output logic              err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {EMPTY, FILLING, READY, STREAM} state_t;
    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [LEN_W-1:0]  len_q, rptr, len_eff;
    logic              len_bad, wr;
    always_comb begin
        len_bad = (len == '0) || (len > LEN_W'(DEPTH));
        len_eff = len_bad ? LEN_W'(DEPTH) : len;
        wr      = sp_wen && !clr && (state == EMPTY || state == FILLING);
    end
    assign ready = state == READY;
    always_ff @(posedge clk)
        if (wr) mem[wcnt[AW-1:0]] <= wdata;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            wcnt   <= '0;
            rptr   <= '0;
            len_q  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
        end else if (clr) begin
            state  <= EMPTY;
            wcnt   <= '0;
            rptr   <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (sp_wen) begin
                    len_q <= len_eff;
                    wcnt  <= LEN_W'(1);
                    state <= (len_eff == LEN_W'(1)) ? READY : FILLING;
                end
                FILLING: if (sp_wen) begin
                    wcnt <= wcnt + LEN_W'(1);
                    if (wcnt + LEN_W'(1) == len_q) state <= READY;
                end
                READY: begin
                    rvalid <= 1'b0;
                    rlast  <= 1'b0;
                    if (start) begin
                        state <= STREAM;
                        rptr  <= '0;
                    end
                end
                STREAM: begin
                    // a stalled cycle only drops valid; rdata and rptr hold
                    if (stall) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                    end else begin
                        rdata  <= mem[rptr[AW-1:0]];
                        rvalid <= 1'b1;
                        rlast  <= rptr == len_q - LEN_W'(1);
                        rptr   <= (rptr == len_q - LEN_W'(1)) ? '0 : rptr + LEN_W'(1);
                        if (rptr == len_q - LEN_W'(1)) state <= READY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
`ifdef FILTER_SP_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (clr) err <= 1'b0;
        else if ((sp_wen && (state == READY || state == STREAM)) ||
                 (start && (state == EMPTY || state == FILLING)) ||
                 (sp_wen && state == EMPTY && len_bad)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_filter_scratchpad.sv
// tb_filter_scratchpad: table-driven load/replay vectors plus hand-written stall, back-to-back, clr and reset sequences.
module tb_filter_scratchpad;
    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, sp_wen = 1'b0, start = 1'b0, stall = 1'b0;
    logic [4:0]  len = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        rvalid, rlast, ready, err;
    logic [4:0]  wcnt;

    filter_scratchpad dut (
        .clk(clk), .rst(rst), .clr(clr), .len(len), .sp_wen(sp_wen), .wdata(wdata),
        .start(start), .stall(stall), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .ready(ready), .wcnt(wcnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] d; logic l;} exp_t;
    typedef struct {int len; int nwr; int eff; bit smid; bit exp_err; int ofs;} vec_t;

    exp_t        q[$];
    int          rl_cyc[$];
    logic [15:0] m [16];
    int          errors = 0, checks = 0, cyc = 0, got = 0;
    bit          err_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (rvalid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rvalid: got rdata 0x%0h with no word expected", rdata);
            end else begin
                e = q.pop_front();
                chk("rdata", 32'(rdata), 32'(e.d));
                chk("rlast", 32'(rlast), 32'(e.l));
                got++;
                if (rlast) rl_cyc.push_back(cyc);
            end
        end else if (rlast) begin
            checks++;
            errors++;
            $display("FAIL rlast_without_rvalid: got rlast 1 expected 0");
        end
    end

    task automatic load(input int n, input int l, input int ofs, input bit smid);
        int e = (l == 0 || l > 16) ? 16 : l;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sp_wen = 1'b1;
            len    = 5'((i == 0) ? l : 7);
            wdata  = 16'((i + 1) * 'h11 + ofs);
            start  = smid && i == 1;
            if (i < e) m[i] = wdata;
        end
        @(negedge clk);
        sp_wen = 1'b0;
        start  = 1'b0;
    endtask

    task automatic push_pass(input int l);
        for (int i = 0; i < l; i++) q.push_back('{m[i], i == l - 1});
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("pending_words", 32'(q.size()), 0);
        q.delete();
    endtask

    task automatic clear;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic replay(input int l);
        int s;
        push_pass(l);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
        wait_done(l + 8);
        chk("rlast_cycle", 32'(rl_cyc[$]), 32'(s + l));
        chk("ready_after_replay", 32'(ready), 1);
    endtask

    vec_t vecs[7];

    initial begin
`ifdef FILTER_SP_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        vecs[0] = '{4, 4, 4, 1'b0, 1'b0, 'h000};
        vecs[1] = '{4, 5, 4, 1'b1, 1'b1, 'h100};
        vecs[2] = '{1, 1, 1, 1'b0, 1'b0, 'h200};
        vecs[3] = '{0, 16, 16, 1'b0, 1'b1, 'h300};
        vecs[4] = '{20, 16, 16, 1'b0, 1'b1, 'h400};
        vecs[5] = '{3, 3, 3, 1'b0, 1'b0, 'h500};
        vecs[6] = '{16, 16, 16, 1'b0, 1'b0, 'h600};

        repeat (2) @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rlast", 32'(rlast), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wcnt", 32'(wcnt), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            clear();
            chk("clr_wcnt", 32'(wcnt), 0);
            chk("clr_ready", 32'(ready), 0);
            chk("clr_err", 32'(err), 0);
            load(vecs[v].nwr, vecs[v].len, vecs[v].ofs, vecs[v].smid);
            chk("load_wcnt", 32'(wcnt), 32'(vecs[v].eff));
            chk("load_ready", 32'(ready), 1);
            chk("load_err", 32'(err), 32'(err_en && vecs[v].exp_err));
            replay(vecs[v].eff);
            chk("replay_wcnt", 32'(wcnt), 32'(vecs[v].eff));
        end

        // stall on the second replay cycle for three cycles
        begin
            int s;
            clear();
            load(4, 4, 0, 1'b0);
            push_pass(4);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            s = cyc;
            @(negedge clk);
            stall = 1'b1;
            @(negedge clk);
            chk("stall_rvalid", 32'(rvalid), 0);
            chk("stall_rdata_hold", 32'(rdata), 'h11);
            repeat (2) @(negedge clk);
            stall = 1'b0;
            wait_done(16);
            chk("stall_rlast_cycle", 32'(rl_cyc[$]), 32'(s + 7));
        end

        // three back-to-back replays with start held high
        begin
            int b, n;
            clear();
            load(3, 3, 'h700, 1'b0);
            b = rl_cyc.size();
            repeat (3) push_pass(3);
            @(negedge clk);
            start = 1'b1;
            n = 0;
            while (rl_cyc.size() < b + 2 && n < 40) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            start = 1'b0;
            wait_done(16);
            chk("b2b_rlast_count", 32'(rl_cyc.size() - b), 3);
            if (rl_cyc.size() >= b + 3) chk("b2b_spacing", 32'(rl_cyc[b+2] - rl_cyc[b]), 8);
            chk("b2b_wcnt", 32'(wcnt), 3);
            replay(3);
        end

        // clr collides with a write mid-fill, then a fresh short load
        begin
            clear();
            load(2, 4, 'h800, 1'b0);
            chk("partial_wcnt", 32'(wcnt), 2);
            chk("partial_ready", 32'(ready), 0);
            @(negedge clk);
            clr    = 1'b1;
            sp_wen = 1'b1;
            wdata  = 16'hdead;
            @(negedge clk);
            clr    = 1'b0;
            sp_wen = 1'b0;
            chk("clrwen_wcnt", 32'(wcnt), 0);
            chk("clrwen_ready", 32'(ready), 0);
            chk("clrwen_err", 32'(err), 0);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            chk("empty_start_ready", 32'(ready), 0);
            chk("empty_start_err", 32'(err), 32'(err_en));
            load(2, 2, 'hA00, 1'b0);
            chk("reload_wcnt", 32'(wcnt), 2);
            replay(2);
        end

        // asynchronous reset in the middle of a replay
        begin
            int g0, n;
            clear();
            load(4, 4, 'hB00, 1'b0);
            push_pass(4);
            g0 = got;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (got < g0 + 2 && n < 20) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("rst_wait_words", 32'(got - g0), 2);
            rst = 1'b1;
            #1;
            chk("midrst_rvalid", 32'(rvalid), 0);
            chk("midrst_rlast", 32'(rlast), 0);
            chk("midrst_rdata", 32'(rdata), 0);
            chk("midrst_wcnt", 32'(wcnt), 0);
            chk("midrst_ready", 32'(ready), 0);
            chk("midrst_err", 32'(err), 0);
            q.delete();
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            chk("postrst_ready", 32'(ready), 0);
            chk("postrst_wcnt", 32'(wcnt), 0);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
